// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC and issues one stable-address read
// per instruction to instruction memory. It absorbs multi-cycle memory
// latency, hazard-unit stalls and EX-stage redirects. The stage always
// drives IF_* from registers; a NOP bubble is emitted when no real word
// can be delivered.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_BUSYWAIT,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_INSTRUCTION,
  output logic [31:0] IF_PC_PLUS4,
  output logic        IF_VALID
);

  // FETCH: request in flight at pc.
  // HOLD: a completed word is parked in the skid while the stage is stalled.
  // DRAIN: a redirect arrived mid-request; wait out the request, then jump.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        run_q;
  logic        complete;
  logic        word_avail;
  logic [31:0] word_instr;
  logic [31:0] word_pc;

  logic [31:0] pc_p0;
  logic [31:0] target_p0;
  logic [31:0] skid_instr_p0;
  logic [31:0] skid_pc_p0;

  logic [31:0] out_pc_p1;
  logic [31:0] out_instr_p1;
  logic [31:0] out_pc4_p1;
  logic        vld_p1;

  // Sequential PC step; wraps modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  // Request status: a word is accepted when a read is requested and memory is ready.
  assign complete = IMEM_READ && !IMEM_BUSYWAIT;

  // State register; run_q keeps the first post-reset cycle request-free.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  // Next-state selection for the fetch handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (complete) begin
          if (!REDIRECT && STALL) state_d = S_HOLD;
        end else if (REDIRECT && run_q) begin
          state_d = S_DRAIN;
        end
      end
      S_HOLD:  if (REDIRECT || !STALL) state_d = S_FETCH;
      S_DRAIN: if (complete) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // Memory-side outputs: the address is always the PC; no request while parked in HOLD.
  always_comb begin
    IMEM_READ = run_q && (state_q != S_HOLD);
    IMEM_ADDR = pc_p0;
  end

  // Word offered to the output stage this cycle, straight from memory or from the skid.
  always_comb begin
    word_avail = 1'b0;
    word_instr = IMEM_RDATA;
    word_pc    = pc_p0;
    if (state_q == S_FETCH && complete) begin
      word_avail = 1'b1;
    end else if (state_q == S_HOLD) begin
      word_avail = 1'b1;
      word_instr = skid_instr_p0;
      word_pc    = skid_pc_p0;
    end
  end

  // ---- stage p0: PC, redirect target and skid buffer ----
  // PC/target/skid updates driven by the handshake state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_p0         <= RESET_PC;
      target_p0     <= 32'h0;
      skid_instr_p0 <= 32'h0;
      skid_pc_p0    <= 32'h0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (complete) begin
            if (REDIRECT) begin
              pc_p0 <= REDIRECT_PC;
            end else begin
              pc_p0 <= pc_inc(pc_p0);
              if (STALL) begin
                skid_instr_p0 <= IMEM_RDATA;
                skid_pc_p0    <= pc_p0;
              end
            end
          end else if (REDIRECT) begin
            // With no request yet in flight there is nothing to drain.
            if (run_q) target_p0 <= REDIRECT_PC;
            else       pc_p0     <= REDIRECT_PC;
          end
        end
        S_HOLD: begin
          if (REDIRECT) pc_p0 <= REDIRECT_PC;
        end
        S_DRAIN: begin
          if (REDIRECT) target_p0 <= REDIRECT_PC;
          if (complete) pc_p0 <= REDIRECT ? REDIRECT_PC : target_p0;
        end
        default: pc_p0 <= pc_p0;
      endcase
    end
  end

  // ---- stage p1: registered IF_* bundle ----
  // Output register: flush on redirect, hold on stall, else deliver or bubble.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_pc_p1    <= 32'h0;
      out_instr_p1 <= NOP_INSTR;
      out_pc4_p1   <= 32'h0;
      vld_p1       <= 1'b0;
    end else if (REDIRECT) begin
      out_instr_p1 <= NOP_INSTR;
      vld_p1       <= 1'b0;
    end else if (!STALL) begin
      if (word_avail) begin
        out_pc_p1    <= word_pc;
        out_instr_p1 <= word_instr;
        out_pc4_p1   <= pc_inc(word_pc);
        vld_p1       <= 1'b1;
      end else begin
        out_instr_p1 <= NOP_INSTR;
        vld_p1       <= 1'b0;
      end
    end
  end

  assign IF_PC          = out_pc_p1;
  assign IF_INSTRUCTION = out_instr_p1;
  assign IF_PC_PLUS4    = out_pc4_p1;
  assign IF_VALID       = vld_p1;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: streaming, memory wait states, stall
// with skid, redirect during a wait, redirect+stall, PC wrap, async reset.
module tb_if_fetch_unit;

  logic        CLK;
  logic        RST;
  logic        STALL;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_BUSYWAIT;
  logic [31:0] IMEM_RDATA;
  logic [31:0] IF_PC;
  logic [31:0] IF_INSTRUCTION;
  logic [31:0] IF_PC_PLUS4;
  logic        IF_VALID;

  logic        w_stall;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_read;
  logic [31:0] w_addr;
  logic        w_busy;
  logic [31:0] w_rdata;
  logic [31:0] w_pc;
  logic [31:0] w_instr;
  logic [31:0] w_pc4;
  logic        w_valid;

  int checks = 0;
  int errors = 0;

  // Memory models: word content derived from its address.
  assign IMEM_RDATA = 32'hDEAD_0000 | {16'h0, IMEM_ADDR[15:0]};
  assign w_rdata    = w_addr ^ 32'h5555_0000;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) u_dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .IMEM_READ(IMEM_READ), .IMEM_ADDR(IMEM_ADDR), .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
    .IMEM_RDATA(IMEM_RDATA), .IF_PC(IF_PC), .IF_INSTRUCTION(IF_INSTRUCTION),
    .IF_PC_PLUS4(IF_PC_PLUS4), .IF_VALID(IF_VALID)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0013)) u_wrap (
    .CLK(CLK), .RST(RST), .STALL(w_stall), .REDIRECT(w_redirect), .REDIRECT_PC(w_redirect_pc),
    .IMEM_READ(w_read), .IMEM_ADDR(w_addr), .IMEM_BUSYWAIT(w_busy),
    .IMEM_RDATA(w_rdata), .IF_PC(w_pc), .IF_INSTRUCTION(w_instr),
    .IF_PC_PLUS4(w_pc4), .IF_VALID(w_valid)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] pc4, input logic vld);
    chk({tag, ".if_pc"}, IF_PC, pc);
    chk({tag, ".if_instr"}, IF_INSTRUCTION, instr);
    chk({tag, ".if_pc4"}, IF_PC_PLUS4, pc4);
    chk({tag, ".if_valid"}, {31'h0, IF_VALID}, {31'h0, vld});
  endtask

  task automatic chk_mem(input string tag, input logic rd, input logic [31:0] addr);
    chk({tag, ".imem_read"}, {31'h0, IMEM_READ}, {31'h0, rd});
    chk({tag, ".imem_addr"}, IMEM_ADDR, addr);
  endtask

  initial begin
    RST = 1'b1; STALL = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = 32'h0; IMEM_BUSYWAIT = 1'b0;
    w_stall = 1'b0; w_redirect = 1'b0; w_redirect_pc = 32'h0; w_busy = 1'b0;

    // Reset state
    tick(); tick();
    chk_mem("rst", 1'b0, 32'h0);
    chk_out("rst", 32'h0, 32'h13, 32'h0, 1'b0);
    chk("rst.wrap_read", {31'h0, w_read}, 32'h0);
    chk("rst.wrap_addr", w_addr, 32'hFFFF_FFFC);
    chk("rst.wrap_pc4", w_pc4, 32'h0);
    RST = 1'b0;

    // Streaming: first request, then one instruction per cycle
    tick();
    chk_mem("e1", 1'b1, 32'h0);
    chk("e1.valid", {31'h0, IF_VALID}, 32'h0);
    chk("e1.wrap_read", {31'h0, w_read}, 32'h1);
    chk("e1.wrap_addr", w_addr, 32'hFFFF_FFFC);
    tick();
    chk_out("e2", 32'h0, 32'hDEAD_0000, 32'h4, 1'b1);
    chk_mem("e2", 1'b1, 32'h4);
    chk("e2.wrap_pc", w_pc, 32'hFFFF_FFFC);
    chk("e2.wrap_pc4", w_pc4, 32'h0);
    chk("e2.wrap_instr", w_instr, 32'hAAAA_FFFC);
    chk("e2.wrap_addr", w_addr, 32'h0);
    tick();
    chk_out("e3", 32'h4, 32'hDEAD_0004, 32'h8, 1'b1);
    chk_mem("e3", 1'b1, 32'h8);
    chk("e3.wrap_pc", w_pc, 32'h0);
    chk("e3.wrap_pc4", w_pc4, 32'h4);
    chk("e3.wrap_instr", w_instr, 32'h5555_0000);

    // Three wait-state cycles at 0x8
    IMEM_BUSYWAIT = 1'b1;
    tick();
    chk_out("w1", 32'h4, 32'h13, 32'h8, 1'b0);
    chk_mem("w1", 1'b1, 32'h8);
    tick();
    chk_out("w2", 32'h4, 32'h13, 32'h8, 1'b0);
    chk_mem("w2", 1'b1, 32'h8);
    tick();
    chk_out("w3", 32'h4, 32'h13, 32'h8, 1'b0);
    chk_mem("w3", 1'b1, 32'h8);
    IMEM_BUSYWAIT = 1'b0;
    tick();
    chk_out("w4", 32'h8, 32'hDEAD_0008, 32'hC, 1'b1);
    chk_mem("w4", 1'b1, 32'hC);

    // Stall two cycles while 0xC completes
    STALL = 1'b1;
    tick();
    chk_out("s1", 32'h8, 32'hDEAD_0008, 32'hC, 1'b1);
    chk_mem("s1", 1'b0, 32'h10);
    tick();
    chk_out("s2", 32'h8, 32'hDEAD_0008, 32'hC, 1'b1);
    chk_mem("s2", 1'b0, 32'h10);
    STALL = 1'b0;
    tick();
    chk_out("s3", 32'hC, 32'hDEAD_000C, 32'h10, 1'b1);
    chk_mem("s3", 1'b1, 32'h10);
    tick();
    chk_out("s4", 32'h10, 32'hDEAD_0010, 32'h14, 1'b1);
    chk_mem("s4", 1'b1, 32'h14);

    // Redirect to 0x100 while the read at 0x14 is waiting
    IMEM_BUSYWAIT = 1'b1; REDIRECT = 1'b1; REDIRECT_PC = 32'h100;
    tick();
    chk_out("r1", 32'h10, 32'h13, 32'h14, 1'b0);
    chk_mem("r1", 1'b1, 32'h14);
    REDIRECT = 1'b0; REDIRECT_PC = 32'h0000_DEAD;
    tick();
    chk_out("r2", 32'h10, 32'h13, 32'h14, 1'b0);
    chk_mem("r2", 1'b1, 32'h14);
    IMEM_BUSYWAIT = 1'b0;
    tick();
    chk_out("r3", 32'h10, 32'h13, 32'h14, 1'b0);
    chk_mem("r3", 1'b1, 32'h100);
    tick();
    chk_out("r4", 32'h100, 32'hDEAD_0100, 32'h104, 1'b1);
    chk_mem("r4", 1'b1, 32'h104);

    // Stall into HOLD, then redirect and stall together: skid word 0x104 dropped
    STALL = 1'b1;
    tick();
    chk_out("h1", 32'h100, 32'hDEAD_0100, 32'h104, 1'b1);
    chk_mem("h1", 1'b0, 32'h108);
    REDIRECT = 1'b1; REDIRECT_PC = 32'h200;
    tick();
    chk_out("h2", 32'h100, 32'h13, 32'h104, 1'b0);
    chk_mem("h2", 1'b1, 32'h200);
    REDIRECT = 1'b0; STALL = 1'b0;
    tick();
    chk_out("h3", 32'h200, 32'hDEAD_0200, 32'h204, 1'b1);
    chk_mem("h3", 1'b1, 32'h204);

    // Asynchronous reset in the middle of a wait
    IMEM_BUSYWAIT = 1'b1;
    tick();
    chk_out("a0", 32'h200, 32'h13, 32'h204, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    chk_mem("a1", 1'b0, 32'h0);
    chk_out("a1", 32'h0, 32'h13, 32'h0, 1'b0);
    tick();
    RST = 1'b0; IMEM_BUSYWAIT = 1'b0;
    tick();
    chk_mem("a2", 1'b1, 32'h0);
    chk("a2.valid", {31'h0, IF_VALID}, 32'h0);
    tick();
    chk_out("a3", 32'h0, 32'hDEAD_0000, 32'h4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
